// File: rtl/sram_stream_master.sv
// rtl/sram_stream_master.sv - byte stream <-> 16-bit SRAM word block transfer initiator
// Optional WAIT timeout with sticky error output: SRAM_MASTER_TIMEOUT_EN.
module sram_stream_master (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_start,
    input  logic        cmd_write,
    input  logic [17:0] cmd_address,
    input  logic [18:0] cmd_count,
    output logic        busy,
    output logic        done,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [7:0]  out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [17:0] m_address,
    output logic [15:0] m_to_mem,
    input  logic [15:0] m_from_mem,
    output logic        m_req,
    output logic        m_wren,
    input  logic        m_ready
`ifdef SRAM_MASTER_TIMEOUT_EN
    ,
    output logic        error
`endif
);

    typedef enum logic [2:0] {
        S_IDLE, S_GET_LO, S_GET_HI, S_REQ, S_WAIT, S_PUT_LO, S_PUT_HI, S_FINISH
    } state_t;

    state_t      r_state;
    logic        r_write;
    logic [18:0] r_count;
    logic [7:0]  r_rd_hi;
`ifdef SRAM_MASTER_TIMEOUT_EN
    logic [7:0]  r_timer;
`endif

    logic w_last;
    assign w_last = (r_count == 19'd1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_write   <= 1'b0;
            r_count   <= 19'd0;
            r_rd_hi   <= 8'd0;
            busy      <= 1'b0;
            done      <= 1'b0;
            in_ready  <= 1'b0;
            out_data  <= 8'd0;
            out_valid <= 1'b0;
            m_address <= 18'd0;
            m_to_mem  <= 16'd0;
            m_req     <= 1'b0;
            m_wren    <= 1'b0;
`ifdef SRAM_MASTER_TIMEOUT_EN
            r_timer   <= 8'd0;
            error     <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (cmd_start) begin
                        m_address <= cmd_address;
                        r_write   <= cmd_write;
                        r_count   <= cmd_count;
                        busy      <= 1'b1;
`ifdef SRAM_MASTER_TIMEOUT_EN
                        error     <= 1'b0;
`endif
                        if (cmd_count == 19'd0) begin
                            r_state <= S_FINISH;
                        end else if (cmd_write) begin
                            r_state  <= S_GET_LO;
                            in_ready <= 1'b1;
                        end else begin
                            r_state <= S_REQ;
                        end
                    end
                end
                // in_ready is held high for the whole GET_LO/GET_HI span
                S_GET_LO: begin
                    if (in_valid) begin
                        m_to_mem[7:0] <= in_data;
                        r_state       <= S_GET_HI;
                    end
                end
                S_GET_HI: begin
                    if (in_valid) begin
                        m_to_mem[15:8] <= in_data;
                        in_ready       <= 1'b0;
                        r_state        <= S_REQ;
                    end
                end
                S_REQ: begin
                    m_req   <= 1'b1;
                    m_wren  <= r_write;
`ifdef SRAM_MASTER_TIMEOUT_EN
                    r_timer <= 8'd0;
`endif
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    if (m_ready) begin
                        m_req     <= 1'b0;
                        m_address <= m_address + 18'd1;
                        r_count   <= r_count - 19'd1;
                        if (!r_write) begin
                            out_data  <= m_from_mem[7:0];
                            r_rd_hi   <= m_from_mem[15:8];
                            out_valid <= 1'b1;
                            r_state   <= S_PUT_LO;
                        end else if (w_last) begin
                            r_state <= S_FINISH;
                        end else begin
                            in_ready <= 1'b1;
                            r_state  <= S_GET_LO;
                        end
                    end
`ifdef SRAM_MASTER_TIMEOUT_EN
                    else if (r_timer == 8'd254) begin
                        m_req   <= 1'b0;
                        error   <= 1'b1;
                        r_state <= S_FINISH;
                    end else begin
                        r_timer <= r_timer + 8'd1;
                    end
`endif
                end
                S_PUT_LO: begin
                    if (out_ready) begin
                        out_data <= r_rd_hi;
                        r_state  <= S_PUT_HI;
                    end
                end
                // r_count was already decremented when the word arrived
                S_PUT_HI: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        r_state   <= (r_count == 19'd0) ? S_FINISH : S_REQ;
                    end
                end
                S_FINISH: begin
                    done    <= 1'b1;
                    busy    <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
